// File: rtl/noc_pkg.sv
// Shared flit-format definitions for the NoC router input stage.
// Flit type sits in the two top bits; route fields sit in the low nibble of HEAD/SINGLE flits.
package noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ROUTED = 1'b1
  } route_state_e;

  // Type-field positions for the reference 32-bit flit; narrower flits shift them down.
  localparam int DEF_DATA_W = 32;
  localparam int FT_MSB     = DEF_DATA_W - 1;
  localparam int FT_LSB     = DEF_DATA_W - 2;
  localparam int COM_W      = 2;
  localparam int COM1_LSB   = 0;
  localparam int COM2_LSB   = 2;

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and an occupancy count.
// Pointers carry one extra bit and wrap naturally; the caller never pushes when full or pops when empty.
module noc_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic [AW:0]       count_reg;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_reg == (AW+1)'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr_reg[AW-1:0]];
  assign count_o = count_reg;

endmodule

// File: rtl/noc_in_buf.sv
// Router input-port buffer: queues wormhole flits and presents the route of the packet in flight.
// A packet's route is latched on its HEAD pop and reused for every flit up to the TAIL.
module noc_in_buf
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  input  logic [DATA_W-1:0]      in_data_i,
  output logic                   in_ready_o,
  input  logic                   grant_i,
  output logic                   valid_o,
  output logic [COM_W-1:0]       com1_o,
  output logic [COM_W-1:0]       com2_o,
  output logic [DATA_W-1:0]      data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   err_o
);

  localparam int TYPE_HI = FT_MSB - DEF_DATA_W + DATA_W;
  localparam int TYPE_LO = FT_LSB - DEF_DATA_W + DATA_W;

  logic [DATA_W-1:0] front;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_pop;

  flit_type_e   front_type;
  logic         front_is_head;
  route_state_e state_reg;
  route_state_e state_next;
  logic [COM_W-1:0] com1_reg;
  logic [COM_W-1:0] com2_reg;
  logic [COM_W-1:0] com1_next;
  logic [COM_W-1:0] com2_next;

  logic             valid_comb;
  logic             err_comb;
  logic [COM_W-1:0] com1_comb;
  logic [COM_W-1:0] com2_comb;

  noc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (in_data_i),
    .pop_i   (fifo_pop),
    .data_o  (front),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign front_type    = flit_type_e'(front[TYPE_HI:TYPE_LO]);
  assign front_is_head = (front_type == FT_HEAD) || (front_type == FT_SINGLE);

  // Readiness uses the registered count only, so a pop never frees a slot in the same cycle.
  assign in_ready_o = !rst_i && !full;
  assign push       = in_valid_i && in_ready_o;

  always_comb begin
    valid_comb = 1'b0;
    err_comb   = 1'b0;
    drop       = 1'b0;
    com1_comb  = '0;
    com2_comb  = '0;
    state_next = state_reg;
    com1_next  = com1_reg;
    com2_next  = com2_reg;
    if (!rst_i && !empty) begin
      case (state_reg)
        IDLE: begin
          if (front_is_head) begin
            valid_comb = 1'b1;
            com1_comb  = front[COM1_LSB +: COM_W];
            com2_comb  = front[COM2_LSB +: COM_W];
            if (grant_i && (front_type == FT_HEAD)) begin
              state_next = ROUTED;
              com1_next  = front[COM1_LSB +: COM_W];
              com2_next  = front[COM2_LSB +: COM_W];
            end
          end else begin
            // Orphan BODY/TAIL with no packet open: discard it and flag.
            drop     = 1'b1;
            err_comb = 1'b1;
          end
        end
        ROUTED: begin
          if (front_is_head) begin
            // Missing tail: close the broken packet; the new head routes next cycle.
            err_comb   = 1'b1;
            state_next = IDLE;
          end else begin
            valid_comb = 1'b1;
            com1_comb  = com1_reg;
            com2_comb  = com2_reg;
            if (grant_i && (front_type == FT_TAIL)) begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign pop      = grant_i && valid_comb;
  assign fifo_pop = pop || drop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      com1_reg  <= '0;
      com2_reg  <= '0;
    end else begin
      state_reg <= state_next;
      com1_reg  <= com1_next;
      com2_reg  <= com2_next;
    end
  end

  assign valid_o = valid_comb;
  assign err_o   = err_comb;
  assign com1_o  = com1_comb;
  assign com2_o  = com2_comb;
  assign data_o  = front;

endmodule

// File: tb/tb_noc_in_buf.sv
// Randomised bench for noc_in_buf against a queue-based packet model, plus directed scenarios.
`timescale 1ns/1ps
module tb_noc_in_buf;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              in_valid_i = 1'b0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              in_ready_o;
  logic              grant_i = 1'b0;
  logic              valid_o;
  logic [1:0]        com1_o;
  logic [1:0]        com2_o;
  logic [DATA_W-1:0] data_o;
  logic [2:0]        count_o;
  logic              err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: flit queue, whether a packet is open, and its route.
  logic [DATA_W-1:0] q[$];
  bit                in_pkt = 0;
  logic [1:0]        r1 = 2'b00, r2 = 2'b00;

  always #5 clk = ~clk;

  noc_in_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .grant_i    (grant_i),
    .valid_o    (valid_o),
    .com1_o     (com1_o),
    .com2_o     (com2_o),
    .data_o     (data_o),
    .count_o    (count_o),
    .err_o      (err_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [1:0] t, input logic [3:0] low);
    logic [DATA_W-1:0] f;
    f = DATA_W'($urandom);
    f[DATA_W-1:DATA_W-2] = t;
    f[3:0] = low;
    return f;
  endfunction

  // One clock: drive, check outputs against the model, then advance the model at the edge.
  task automatic cycle(input bit r, input bit v, input logic [DATA_W-1:0] d, input bit g);
    bit e_ready, e_valid, e_err, drop, close_pkt, do_push, do_pop;
    logic [1:0] e_c1, e_c2, t;
    logic [DATA_W-1:0] f;
    @(negedge clk);
    rst_i = r; in_valid_i = v; in_data_i = d; grant_i = g;
    #1;
    e_ready = 0; e_valid = 0; e_err = 0; e_c1 = 0; e_c2 = 0; drop = 0; close_pkt = 0;
    f = '0; t = 2'b00;
    if (!r) begin
      e_ready = (q.size() < DEPTH);
      if (q.size() > 0) begin
        f = q[0];
        t = f[DATA_W-1:DATA_W-2];
        if (!in_pkt) begin
          if (t == T_HEAD || t == T_SINGLE) begin
            e_valid = 1; e_c1 = f[1:0]; e_c2 = f[3:2];
          end else begin
            e_err = 1; drop = 1;
          end
        end else begin
          if (t == T_HEAD || t == T_SINGLE) begin
            e_err = 1; close_pkt = 1;
          end else begin
            e_valid = 1; e_c1 = r1; e_c2 = r2;
          end
        end
      end
      check_eq("count", count_o, q.size());
    end
    check_eq("in_ready", in_ready_o, e_ready);
    check_eq("valid", valid_o, e_valid);
    check_eq("err", err_o, e_err);
    check_eq("com1", com1_o, e_c1);
    check_eq("com2", com2_o, e_c2);
    if (e_valid) check_eq("data", data_o, f);
    @(posedge clk);
    if (r) begin
      q.delete(); in_pkt = 0; r1 = 0; r2 = 0;
    end else begin
      do_pop  = g && e_valid;
      do_push = v && e_ready;
      if (drop) void'(q.pop_front());
      if (close_pkt) in_pkt = 0;
      if (do_pop) begin
        if (!in_pkt && t == T_HEAD) begin
          in_pkt = 1; r1 = f[1:0]; r2 = f[3:2];
        end else if (in_pkt && t == T_TAIL) begin
          in_pkt = 0;
        end
        void'(q.pop_front());
      end
      if (do_push) q.push_back(d);
      if (do_push || do_pop || drop)
        $display("t=%0t push=%0b pop=%0b drop=%0b occ=%0d", $time, do_push, do_pop, drop, q.size());
    end
  endtask

  // Look at registered-state outputs just after an edge, without consuming a cycle.
  task automatic peek(input string tag, input bit e_valid, input logic [1:0] e_c1,
                      input logic [1:0] e_c2, input logic [2:0] e_cnt);
    #1;
    check_eq({tag, ".valid"}, valid_o, e_valid);
    check_eq({tag, ".com1"}, com1_o, e_c1);
    check_eq({tag, ".com2"}, com2_o, e_c2);
    check_eq({tag, ".count"}, count_o, e_cnt);
  endtask

  initial begin
    logic [1:0] tt;
    // Reset
    cycle(1, 0, '0, 0);
    cycle(1, 0, '0, 0);
    #1;
    check_eq("rst.in_ready", in_ready_o, 1'b0);
    check_eq("rst.err", err_o, 1'b0);
    cycle(0, 0, '0, 0);
    #1;
    check_eq("post_rst.in_ready", in_ready_o, 1'b1);
    check_eq("post_rst.count", count_o, 3'd0);

    // SINGLE flit
    cycle(0, 1, mk(T_SINGLE, 4'b0001), 0);
    peek("single", 1, 2'b01, 2'b00, 3'd1);
    cycle(0, 0, '0, 1);
    peek("single_pop", 0, 2'b00, 2'b00, 3'd0);

    // HEAD / BODY / TAIL keep the head's route
    cycle(0, 1, mk(T_HEAD, 4'b0010), 0);
    peek("head", 1, 2'b10, 2'b00, 3'd1);
    cycle(0, 1, mk(T_BODY, 4'b1111), 1);
    peek("body", 1, 2'b10, 2'b00, 3'd1);
    cycle(0, 1, mk(T_TAIL, 4'b0101), 1);
    peek("tail", 1, 2'b10, 2'b00, 3'd1);
    cycle(0, 0, '0, 1);
    peek("pkt_done", 0, 2'b00, 2'b00, 3'd0);

    // Fill to full, then grant+push is refused
    cycle(0, 1, mk(T_HEAD, 4'b1001), 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, mk(T_BODY, 4'($urandom)), 0);
    #1;
    check_eq("full.count", count_o, 3'd4);
    check_eq("full.in_ready", in_ready_o, 1'b0);
    cycle(0, 1, mk(T_BODY, 4'b0000), 1);
    #1;
    check_eq("full_pop.count", count_o, 3'd3);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);
    cycle(0, 1, mk(T_TAIL, 4'b0000), 0);
    cycle(0, 0, '0, 1);

    // Orphan BODY in IDLE
    cycle(0, 1, mk(T_BODY, 4'b0110), 0);
    #1;
    check_eq("orphan.err", err_o, 1'b1);
    check_eq("orphan.valid", valid_o, 1'b0);
    cycle(0, 0, '0, 0);
    #1;
    check_eq("orphan.err_clear", err_o, 1'b0);
    check_eq("orphan.count", count_o, 3'd0);

    // Reset mid-packet
    cycle(0, 1, mk(T_HEAD, 4'b0111), 0);
    cycle(0, 1, mk(T_BODY, 4'b0000), 1);
    cycle(0, 1, mk(T_TAIL, 4'b0000), 0);
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 0);
    #1;
    check_eq("midrst.count", count_o, 3'd0);
    check_eq("midrst.valid", valid_o, 1'b0);
    cycle(0, 1, mk(T_SINGLE, 4'b1110), 0);
    peek("midrst_single", 1, 2'b10, 2'b11, 3'd1);
    cycle(0, 0, '0, 1);

    // Random traffic, mostly well-formed with occasional protocol errors
    for (int i = 0; i < 3000; i++) begin
      tt = 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            mk(tt, 4'($urandom)), ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
